// File: rtl/wb_pkg.sv
// Shared Wishbone master types: FSM state encoding, default bus widths,
// and request/response records.
package wb_pkg;

   localparam int unsigned WB_AW = 30;
   localparam int unsigned WB_DW = 32;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQUEST = 2'd1;
   localparam logic [1:0] ST_WAIT    = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE    = ST_IDLE,
      S_REQUEST = ST_REQUEST,
      S_WAIT    = ST_WAIT
   } wb_state_t;

   typedef struct packed {
      logic                  we;
      logic [WB_AW-1:0]      addr;
      logic [WB_DW-1:0]      data;
      logic [WB_DW/8-1:0]    sel;
   } wb_req_t;

   typedef struct packed {
      logic [WB_DW-1:0]      data;
      logic                  err;
      logic                  timeout;
   } wb_rsp_t;

endpackage

// File: rtl/wb_master_timeout_counter.sv
// Cycle counter that flags the last cycle before a programmable limit.
// A LIMIT of 0 disables expiry entirely.
module wb_timeout_counter
   import wb_pkg::*;
#(
   parameter int unsigned LIMIT = 1024,
   parameter int unsigned TW    = 16
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam logic [TW-1:0] LAST = (LIMIT == 0) ? '0 : TW'(LIMIT - 1);

   logic [TW-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear)
         r_count <= '0;
      else if (i_enable)
         r_count <= r_count + 1'b1;
   end

   generate
      if (LIMIT == 0) begin : g_disabled
         logic w_unused;
         assign w_unused = ^r_count;
         assign o_expire = 1'b0;
      end else begin : g_enabled
         assign o_expire = i_enable && (r_count == LAST);
      end
   endgenerate

endmodule

// File: rtl/wb_master.sv
// Single-outstanding Wishbone B4 pipelined initiator: one command in,
// one bus cycle out, one response pulse back.
module wb_master
   import wb_pkg::*;
#(
   parameter int unsigned AW             = WB_AW,
   parameter int unsigned DW             = WB_DW,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned TW             = 16
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic            i_req_we,
   input  logic [AW-1:0]   i_req_addr,
   input  logic [DW-1:0]   i_req_data,
   input  logic [DW/8-1:0] i_req_sel,
   output logic            o_rsp_valid,
   output logic [DW-1:0]   o_rsp_data,
   output logic            o_rsp_err,
   output logic            o_rsp_timeout,
   output logic            o_wb_cyc,
   output logic            o_wb_stb,
   output logic            o_wb_we,
   output logic [AW-1:0]   o_wb_addr,
   output logic [DW-1:0]   o_wb_data,
   output logic [DW/8-1:0] o_wb_sel,
   input  logic            i_wb_ack,
   input  logic            i_wb_err,
   input  logic            i_wb_stall,
   input  logic [DW-1:0]   i_wb_data
);

   wb_state_t r_state;
   logic      w_accept;
   logic      w_busy;
   logic      w_expire;

   assign o_req_ready = (r_state == S_IDLE) && !i_reset;
   assign w_accept    = i_req_valid && o_req_ready;
   assign w_busy      = (r_state == S_REQUEST) || (r_state == S_WAIT);

   wb_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES),
      .TW    (TW)
   ) u_timeout (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clear  (w_accept),
      .i_enable (w_busy),
      .o_expire (w_expire)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         o_wb_cyc      <= 1'b0;
         o_wb_stb      <= 1'b0;
         o_wb_we       <= 1'b0;
         o_wb_addr     <= '0;
         o_wb_data     <= '0;
         o_wb_sel      <= '0;
         o_rsp_valid   <= 1'b0;
         o_rsp_data    <= '0;
         o_rsp_err     <= 1'b0;
         o_rsp_timeout <= 1'b0;
      end else begin
         o_rsp_valid   <= 1'b0;
         o_rsp_data    <= '0;
         o_rsp_err     <= 1'b0;
         o_rsp_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  o_wb_we   <= i_req_we;
                  o_wb_addr <= i_req_addr;
                  o_wb_data <= i_req_data;
                  o_wb_sel  <= i_req_sel;
                  o_wb_cyc  <= 1'b1;
                  o_wb_stb  <= 1'b1;
                  r_state   <= S_REQUEST;
               end
            end
            S_REQUEST, S_WAIT: begin
               // Slave completion outranks the timeout; err outranks ack.
               if (i_wb_ack || i_wb_err) begin
                  o_wb_cyc    <= 1'b0;
                  o_wb_stb    <= 1'b0;
                  o_rsp_valid <= 1'b1;
                  o_rsp_err   <= i_wb_err;
                  o_rsp_data  <= (i_wb_err || o_wb_we) ? '0 : i_wb_data;
                  r_state     <= S_IDLE;
               end else if (w_expire) begin
                  o_wb_cyc      <= 1'b0;
                  o_wb_stb      <= 1'b0;
                  o_rsp_valid   <= 1'b1;
                  o_rsp_err     <= 1'b1;
                  o_rsp_timeout <= 1'b1;
                  r_state       <= S_IDLE;
               end else if ((r_state == S_REQUEST) && !i_wb_stall) begin
                  o_wb_stb <= 1'b0;
                  r_state  <= S_WAIT;
               end
            end
            default: begin
               o_wb_cyc <= 1'b0;
               o_wb_stb <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule
